// File: rtl/controle_medidas_hcsr04.sv
// ----------------------------------------------------------------------------
// controle_medidas_hcsr04
// Sequencer in front of the HC-SR04 interface. Each round takes 2^N_LOG2
// samples, pulsing the interface reset between samples because the
// interface parks in its final state. Each attempt is bounded by a
// watchdog. After MAX_FALHAS consecutive timeouts on one sample, the round
// is discarded and the sticky error flag is raised. Rounds repeat every
// PERIODO cycles while ligar is held.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   ligar        level; enables periodic measurement
//   pronto_if    interface ready, medida_if valid while high
//   medida_if    interface distance sample
//   reset_if     one-cycle reset pulse to the interface
//   medir_if     one-cycle measure pulse to the interface
//   media        last published average
//   media_valida one-cycle pulse when media updates
//   erro_sensor  sticky error flag, cleared by the next good round
//   db_estado    current state code
//
// state   | meaning
// INICIAL | idle, waiting for ligar
// LIMPA   | reset interface, clear round counters
// DISPARA | trigger one measurement
// AGUARDA | wait for pronto_if under watchdog
// ACUMULA | add captured sample to accumulator
// REARMA  | reset interface between samples
// FALHA   | attempt timed out, count failure
// ERRO    | too many failures, discard round
// CALCULA | compute average
// PUBLICA | announce new average
// ESPERA  | wait for next period
// ----------------------------------------------------------------------------
module controle_medidas_hcsr04 #(
    parameter int LARGURA    = 12,
    parameter int N_LOG2     = 2,
    parameter int PERIODO    = 50000000,
    parameter int WATCHDOG   = 3000000,
    parameter int MAX_FALHAS = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ligar,
    input  logic               pronto_if,
    input  logic [LARGURA-1:0] medida_if,
    output logic               reset_if,
    output logic               medir_if,
    output logic [LARGURA-1:0] media,
    output logic               media_valida,
    output logic               erro_sensor,
    output logic [3:0]         db_estado
);

    localparam int ACC_W = LARGURA + N_LOG2;
    localparam int AMO_W = N_LOG2 + 1;
    localparam int WD_W  = ($clog2(WATCHDOG) > 0) ? $clog2(WATCHDOG) : 1;
    localparam int PER_W = ($clog2(PERIODO) > 0) ? $clog2(PERIODO) : 1;
    localparam int FAL_W = ($clog2(MAX_FALHAS + 1) > 0) ? $clog2(MAX_FALHAS + 1) : 1;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        LIMPA   = 4'd1,
        DISPARA = 4'd2,
        AGUARDA = 4'd3,
        ACUMULA = 4'd4,
        REARMA  = 4'd5,
        FALHA   = 4'd6,
        ERRO    = 4'd7,
        CALCULA = 4'd8,
        PUBLICA = 4'd9,
        ESPERA  = 4'd10
    } estado_t;

    estado_t            estado_q;
    logic [ACC_W-1:0]   acumulador_q;
    logic [LARGURA-1:0] amostra_q;
    logic [AMO_W-1:0]   amostras_q;
    logic [FAL_W-1:0]   falhas_q;
    logic [WD_W-1:0]    watchdog_q;
    logic [PER_W-1:0]   periodo_q;
    logic [LARGURA-1:0] media_q;
    logic               erro_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= INICIAL;
            acumulador_q <= '0;
            amostra_q    <= '0;
            amostras_q   <= '0;
            falhas_q     <= '0;
            watchdog_q   <= '0;
            periodo_q    <= '0;
            media_q      <= '0;
            erro_q       <= 1'b0;
        end else begin
            case (estado_q)
                INICIAL: begin
                    if (ligar) estado_q <= LIMPA;
                end
                LIMPA: begin
                    acumulador_q <= '0;
                    amostras_q   <= '0;
                    falhas_q     <= '0;
                    watchdog_q   <= '0;
                    estado_q     <= DISPARA;
                end
                DISPARA: begin
                    watchdog_q <= '0;
                    estado_q   <= AGUARDA;
                end
                AGUARDA: begin
                    watchdog_q <= watchdog_q + WD_W'(1);
                    // A sample arriving on the expiry cycle is still accepted.
                    if (pronto_if) begin
                        amostra_q <= medida_if;
                        estado_q  <= ACUMULA;
                    end else if (watchdog_q == WD_W'(WATCHDOG - 1)) begin
                        estado_q <= FALHA;
                    end
                end
                ACUMULA: begin
                    acumulador_q <= acumulador_q + ACC_W'(amostra_q);
                    amostras_q   <= amostras_q + AMO_W'(1);
                    falhas_q     <= '0;
                    if (amostras_q + AMO_W'(1) == AMO_W'(1 << N_LOG2))
                        estado_q <= CALCULA;
                    else
                        estado_q <= REARMA;
                end
                REARMA: begin
                    estado_q <= DISPARA;
                end
                FALHA: begin
                    falhas_q <= falhas_q + FAL_W'(1);
                    if (falhas_q + FAL_W'(1) == FAL_W'(MAX_FALHAS))
                        estado_q <= ERRO;
                    else
                        estado_q <= DISPARA;
                end
                ERRO: begin
                    erro_q    <= 1'b1;
                    periodo_q <= '0;
                    estado_q  <= ESPERA;
                end
                CALCULA: begin
                    // Divide by the sample count by dropping the low bits.
                    media_q  <= acumulador_q[ACC_W-1:N_LOG2];
                    erro_q   <= 1'b0;
                    estado_q <= PUBLICA;
                end
                PUBLICA: begin
                    periodo_q <= '0;
                    estado_q  <= ESPERA;
                end
                ESPERA: begin
                    if (!ligar)
                        estado_q <= INICIAL;
                    else if (periodo_q == PER_W'(PERIODO - 1))
                        estado_q <= LIMPA;
                    else
                        periodo_q <= periodo_q + PER_W'(1);
                end
                default: estado_q <= INICIAL;
            endcase
        end
    end

    assign reset_if     = (estado_q == LIMPA) || (estado_q == REARMA) || (estado_q == FALHA);
    assign medir_if     = (estado_q == DISPARA);
    assign media_valida = (estado_q == PUBLICA);
    assign media        = media_q;
    assign erro_sensor  = erro_q;
    assign db_estado    = (estado_q > ESPERA) ? 4'b1110 : estado_q;

endmodule

// File: tb/tb_controle_medidas_hcsr04.sv
module tb_controle_medidas_hcsr04;

    logic        clock = 1'b0;
    logic        reset;
    logic        ligar;
    logic        pronto_if;
    logic [11:0] medida_if;
    logic        reset_if;
    logic        medir_if;
    logic [11:0] media;
    logic        media_valida;
    logic        erro_sensor;
    logic [3:0]  db_estado;

    always #5 clock = ~clock;

    controle_medidas_hcsr04 #(
        .LARGURA(12), .N_LOG2(2), .PERIODO(20), .WATCHDOG(10), .MAX_FALHAS(3)
    ) dut (
        .clock(clock), .reset(reset), .ligar(ligar),
        .pronto_if(pronto_if), .medida_if(medida_if),
        .reset_if(reset_if), .medir_if(medir_if),
        .media(media), .media_valida(media_valida),
        .erro_sensor(erro_sensor), .db_estado(db_estado)
    );

    int n_vec = 0;
    int n_err = 0;

    // Sensor response queue: delay in cycles after medir_if, 0 = never answers.
    int          dq[$];
    logic [11:0] vq[$];

    // Pulse counters.
    int n_medir = 0;
    int n_rst   = 0;
    int n_val   = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (medir_if)     n_medir++;
            if (reset_if)     n_rst++;
            if (media_valida) n_val++;
        end
    end

    // Sensor model.
    initial begin
        int d;
        logic [11:0] v;
        pronto_if = 1'b0;
        medida_if = '0;
        forever begin
            @(negedge clock);
            if (medir_if && !reset) begin
                d = 0;
                v = '0;
                if (dq.size() > 0) begin
                    d = dq.pop_front();
                    v = vq.pop_front();
                end
                if (d > 0) begin
                    repeat (d) @(negedge clock);
                    pronto_if = 1'b1;
                    medida_if = v;
                    @(negedge clock);
                    pronto_if = 1'b0;
                    medida_if = '0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        int k = 0;
        while (int'(db_estado) != s && k < budget) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk(nm, int'(db_estado), s);
    endtask

    // Round table.
    typedef struct {
        int          first;
        int          n;
        int          ev;
        logic [11:0] em;
        int          ee;
        int          enm;
        int          enr;
    } vec_t;

    vec_t        tbl[16];
    int          nv = 0;
    int          att_d[64];
    logic [11:0] att_v[64];
    int          na = 0;

    task automatic att(input int d, input logic [11:0] v);
        att_d[na] = d;
        att_v[na] = v;
        na++;
    endtask

    task automatic addv(input int n, input int ev, input logic [11:0] em,
                        input int ee, input int enm, input int enr);
        tbl[nv].first = na - n;
        tbl[nv].n     = n;
        tbl[nv].ev    = ev;
        tbl[nv].em    = em;
        tbl[nv].ee    = ee;
        tbl[nv].enm   = enm;
        tbl[nv].enr   = enr;
        nv++;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int s_m, s_r, s_v, cyc;

        // nominal: 100..106 -> 103
        att(4, 100); att(4, 102); att(4, 104); att(4, 106);
        addv(4, 1, 12'd103, 0, 4, 4);
        // single timeout on sample 2, retried
        att(4, 200); att(0, 0); att(4, 200); att(4, 200); att(4, 200);
        addv(5, 1, 12'd200, 0, 5, 5);
        // persistent failure: media kept, error raised
        att(0, 0); att(0, 0); att(0, 0);
        addv(3, 0, 12'd200, 1, 3, 4);
        // good round clears error
        att(4, 100); att(4, 102); att(4, 104); att(4, 106);
        addv(4, 1, 12'd103, 0, 4, 4);
        // pronto on the watchdog expiry cycle
        att(10, 10); att(10, 20); att(4, 30); att(10, 40);
        addv(4, 1, 12'd25, 0, 4, 4);
        // truncating average: 9/4
        att(4, 1); att(4, 2); att(4, 3); att(4, 3);
        addv(4, 1, 12'd2, 0, 4, 4);
        // full-scale samples, no accumulator overflow
        att(4, 4095); att(4, 4095); att(4, 4095); att(4, 4095);
        addv(4, 1, 12'd4095, 0, 4, 4);
        // two failures on two samples, counter cleared by success
        att(0, 0); att(0, 0); att(4, 8); att(4, 8); att(0, 0); att(0, 0); att(4, 8); att(4, 8);
        addv(8, 1, 12'd8, 0, 8, 8);

        reset = 1'b1;
        ligar = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_db_estado", int'(db_estado), 0);
        chk("rst_media", int'(media), 0);
        chk("rst_erro", int'(erro_sensor), 0);
        chk("rst_reset_if", int'(reset_if), 0);
        chk("rst_medir_if", int'(medir_if), 0);
        chk("rst_media_valida", int'(media_valida), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < nv; i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                dq.push_back(att_d[tbl[i].first + k]);
                vq.push_back(att_v[tbl[i].first + k]);
            end
            s_m = n_medir; s_r = n_rst; s_v = n_val;
            @(negedge clock);
            ligar = 1'b1;
            @(negedge clock);
            #1;
            wait_state(10, 600, $sformatf("v%0d_espera", i));
            ligar = 1'b0;
            @(negedge clock);
            #1;
            chk($sformatf("v%0d_inicial", i), int'(db_estado), 0);
            chk($sformatf("v%0d_medir_pulses", i), n_medir - s_m, tbl[i].enm);
            chk($sformatf("v%0d_reset_pulses", i), n_rst - s_r, tbl[i].enr);
            chk($sformatf("v%0d_valid_pulses", i), n_val - s_v, tbl[i].ev);
            chk($sformatf("v%0d_media", i), int'(media), int'(tbl[i].em));
            chk($sformatf("v%0d_erro", i), int'(erro_sensor), tbl[i].ee);
            chk($sformatf("v%0d_queue_left", i), dq.size(), 0);
        end

        // Periodicity, then ligar dropped mid-round.
        for (int k = 0; k < 8; k++) begin
            dq.push_back(4);
            vq.push_back(12'd50);
        end
        @(negedge clock);
        ligar = 1'b1;
        @(negedge clock);
        #1;
        wait_state(10, 600, "per_first_espera");
        s_m = n_medir; s_v = n_val;
        cyc = 0;
        while (db_estado != 4'd1 && cyc < 40) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        chk("per_espera_to_limpa", cyc, 20);
        ligar = 1'b0;
        @(negedge clock);
        #1;
        wait_state(10, 600, "per_second_espera");
        chk("per_valid_after_drop", n_val - s_v, 1);
        chk("per_media_after_drop", int'(media), 50);
        repeat (30) @(negedge clock);
        #1;
        chk("per_idle_state", int'(db_estado), 0);
        chk("per_no_extra_medir", n_medir - s_m, 4);

        // Reset in the middle of AGUARDA.
        dq.push_back(0);
        vq.push_back(12'd0);
        ligar = 1'b1;
        @(negedge clock);
        #1;
        wait_state(3, 50, "rst_reach_aguarda");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst_db_estado", int'(db_estado), 0);
        chk("midrst_media", int'(media), 0);
        chk("midrst_erro", int'(erro_sensor), 0);
        chk("midrst_reset_if", int'(reset_if), 0);
        chk("midrst_medir_if", int'(medir_if), 0);
        ligar = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        chk("midrst_stays_idle", int'(db_estado), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
